// File: rtl/neuron_weight_loader.sv
// Stream-fed weight/enable loader for one neuron. Words are gathered into a
// shadow bank and only copied into the active bank once a complete,
// well-formed frame has arrived and the neuron is not frozen.
//
// state   | meaning
// IDLE    | waiting for the mask word of a new frame
// LOAD    | collecting weights into the shadow bank
// DRAIN   | overlong frame, discarding words until s_last
// COMMIT  | frame complete, waiting for n_freeze low to copy shadow -> active
// ERR_END | single-word frame, report the error and return to IDLE
module neuron_weight_loader #(
  parameter int N_INPUTS = 32,
  parameter int WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [WIDTH-1:0]                 s_data,
  input  logic                             s_last,
  input  logic                             n_freeze,
  output logic [N_INPUTS:0][WIDTH-1:0]     n_weights,
  output logic [N_INPUTS-1:0]              n_enabled,
  output logic                             n_busy,
  output logic                             n_load_done,
  output logic                             n_load_err
);

  localparam int FRAME_LEN = N_INPUTS + 2;
  localparam int CTR_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_COMMIT, S_ERR_END
  } state_t;

  state_t                          state_q, state_d;
  logic [CTR_W-1:0]                ctr_q, ctr_d;
  logic                            rdy_q;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [N_INPUTS:0][WIDTH-1:0]    sh_w_q;
  logic [N_INPUTS-1:0]             sh_mask_q;
  logic [N_INPUTS:0][WIDTH-1:0]    act_w_q;
  logic [N_INPUTS-1:0]             act_mask_q;
  logic                            wr_mask, wr_wt, commit;
  logic                            xfer;
  logic [CTR_W-1:0]                widx;

  // rdy_q keeps s_ready low until the first edge after reset release
  assign s_ready = rdy_q && (state_q == S_IDLE || state_q == S_LOAD
                             || state_q == S_DRAIN);
  assign xfer    = s_valid && s_ready;
  assign widx    = ctr_q - CTR_W'(1);

  assign n_weights   = act_w_q;
  assign n_enabled   = act_mask_q;
  assign n_busy      = (state_q != S_IDLE);
  assign n_load_done = done_q;
  assign n_load_err  = err_q;

  // Next-state, counter and pulse decode
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_mask = 1'b0;
    wr_wt   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          wr_mask = 1'b1;
          if (s_last) begin
            state_d = S_ERR_END;
            ctr_d   = '0;
          end else begin
            state_d = S_LOAD;
            ctr_d   = CTR_W'(1);
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_wt = 1'b1;
          if (ctr_q == LAST_IDX) begin
            ctr_d   = '0;
            state_d = s_last ? S_COMMIT : S_DRAIN;
            err_d   = !s_last;
          end else if (s_last) begin
            ctr_d   = '0;
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (xfer && s_last) state_d = S_IDLE;
      end
      S_COMMIT: begin
        if (!n_freeze) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR_END: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rdy_q   <= 1'b1;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Shadow bank capture and atomic copy to the active bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_w_q     <= '0;
      sh_mask_q  <= '0;
      act_w_q    <= '0;
      act_mask_q <= '0;
    end else begin
      if (wr_mask) sh_mask_q <= s_data[N_INPUTS-1:0];
      if (wr_wt)   sh_w_q[widx] <= s_data;
      if (commit) begin
        act_w_q    <= sh_w_q;
        act_mask_q <= sh_mask_q;
      end
    end
  end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Directed bench for neuron_weight_loader: good frames, freeze hold, short,
// long and single-word frames, and reset in the middle of a frame.
module tb_neuron_weight_loader;

  localparam int NI = 32;
  localparam int W  = 32;

  logic                    clk;
  logic                    rst;
  logic                    s_valid;
  logic                    s_ready;
  logic [W-1:0]            s_data;
  logic                    s_last;
  logic                    n_freeze;
  logic [NI:0][W-1:0]      n_weights;
  logic [NI-1:0]           n_enabled;
  logic                    n_busy;
  logic                    n_load_done;
  logic                    n_load_err;

  int n_checks;
  int n_errors;

  logic [W-1:0]  exp_w [0:NI];
  logic [NI-1:0] exp_mask;

  neuron_weight_loader #(.N_INPUTS(NI), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .n_freeze(n_freeze),
    .n_weights(n_weights), .n_enabled(n_enabled), .n_busy(n_busy),
    .n_load_done(n_load_done), .n_load_err(n_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    chk({tag, "_mask"}, 64'(n_enabled), 64'(exp_mask));
    for (int i = 0; i <= NI; i++)
      chk({tag, "_w"}, 64'(n_weights[i]), 64'(exp_w[i]));
  endtask

  // Entered and left just after a negedge; returns after the handshake edge.
  task automatic send_word(input logic [W-1:0] d, input logic l);
    logic seen;
    int   cnt;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    cnt = 0;
    forever begin
      seen = s_ready;
      @(negedge clk);
      if (seen) break;
      cnt++;
      if (cnt > 50) begin
        chk("handshake_timeout", 64'd1, 64'd0);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Sends mask and all weights; weight[i] = base + i. Last handshake just done on return.
  task automatic send_frame(input logic [W-1:0] mask, input logic [W-1:0] base,
                            input bit rnd_gaps);
    send_word(mask, 1'b0);
    for (int i = 0; i <= NI; i++) begin
      if (rnd_gaps) gap(int'($urandom_range(0, 2)));
      send_word(base + W'(i), (i == NI));
    end
  endtask

  // Called right after the last handshake edge with n_freeze low.
  task automatic expect_commit(input string tag, input logic [W-1:0] mask,
                               input logic [W-1:0] base);
    chk({tag, "_done_early"}, 64'(n_load_done), 64'd0);
    check_bank({tag, "_old"});
    @(negedge clk);
    chk({tag, "_done"}, 64'(n_load_done), 64'd1);
    chk({tag, "_err"}, 64'(n_load_err), 64'd0);
    exp_mask = mask[NI-1:0];
    for (int i = 0; i <= NI; i++) exp_w[i] = base + W'(i);
    check_bank({tag, "_new"});
    chk({tag, "_busy"}, 64'(n_busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(n_load_done), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    n_freeze = 1'b0;
    exp_mask = '0;
    for (int i = 0; i <= NI; i++) exp_w[i] = '0;

    // Reset state
    #2;
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(n_busy), 64'd0);
    chk("rst_done", 64'(n_load_done), 64'd0);
    chk("rst_err", 64'(n_load_err), 64'd0);
    check_bank("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready_before_edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("rel_ready_after_edge", 64'(s_ready), 64'd1);

    // 1: full frame, no freeze
    send_frame(32'hFFFF_FFFF, 32'd1, 1'b0);
    expect_commit("t1", 32'hFFFF_FFFF, 32'd1);
    chk("t1_w0", 64'(n_weights[0]), 64'd1);
    chk("t1_bias", 64'(n_weights[NI]), 64'd33);

    // 2: random gaps, freeze held 5 cycles in COMMIT
    send_word(32'h0F0F_0F0F, 1'b0);
    for (int i = 0; i <= NI; i++) begin
      gap(int'($urandom_range(0, 2)));
      if (i == NI) n_freeze = 1'b1;
      send_word(32'h100 + W'(i), (i == NI));
    end
    for (int c = 0; c < 5; c++) begin
      chk("t2_frz_ready", 64'(s_ready), 64'd0);
      chk("t2_frz_busy", 64'(n_busy), 64'd1);
      chk("t2_frz_done", 64'(n_load_done), 64'd0);
      check_bank("t2_frz");
      @(negedge clk);
    end
    n_freeze = 1'b0;
    expect_commit("t2", 32'h0F0F_0F0F, 32'h100);
    gap(3);
    chk("t2_single_done", 64'(n_load_done), 64'd0);

    // 3: s_last on the 10th word (mask + 9 weights)
    send_word(32'hAAAA_5555, 1'b0);
    for (int i = 0; i < 9; i++) send_word(32'h7700 + W'(i), (i == 8));
    chk("t3_err", 64'(n_load_err), 64'd1);
    chk("t3_done", 64'(n_load_done), 64'd0);
    chk("t3_busy", 64'(n_busy), 64'd0);
    chk("t3_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    chk("t3_err_1cyc", 64'(n_load_err), 64'd0);
    check_bank("t3");

    // 4: 40 words, s_last only on word 40
    for (int k = 1; k <= 40; k++) begin
      send_word(32'h5000 + W'(k), (k == 40));
      if (k == 34) begin
        chk("t4_err34", 64'(n_load_err), 64'd1);
        chk("t4_busy34", 64'(n_busy), 64'd1);
      end else begin
        chk("t4_noerr", 64'(n_load_err), 64'd0);
      end
      chk("t4_nodone", 64'(n_load_done), 64'd0);
    end
    chk("t4_idle", 64'(n_busy), 64'd0);
    @(negedge clk);
    chk("t4_noerr_end", 64'(n_load_err), 64'd0);
    check_bank("t4");
    send_frame(32'h1234_5678, 32'hA000_0000, 1'b0);
    expect_commit("t4g", 32'h1234_5678, 32'hA000_0000);

    // 5: single-word frame
    send_word(32'hDEAD_BEEF, 1'b1);
    chk("t5_errend_busy", 64'(n_busy), 64'd1);
    chk("t5_errend_err", 64'(n_load_err), 64'd0);
    @(negedge clk);
    chk("t5_err", 64'(n_load_err), 64'd1);
    chk("t5_busy", 64'(n_busy), 64'd0);
    chk("t5_done", 64'(n_load_done), 64'd0);
    @(negedge clk);
    chk("t5_err_1cyc", 64'(n_load_err), 64'd0);
    check_bank("t5");

    // 6: reset during LOAD at word 12
    send_word(32'hFFFF_0000, 1'b0);
    for (int i = 0; i < 11; i++) send_word(32'h9900 + W'(i), 1'b0);
    chk("t6_busy_pre", 64'(n_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_mask = '0;
    for (int i = 0; i <= NI; i++) exp_w[i] = '0;
    check_bank("t6_rst");
    chk("t6_rst_ready", 64'(s_ready), 64'd0);
    chk("t6_rst_busy", 64'(n_busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_done", 64'(n_load_done), 64'd0);
    chk("t6_rst_err", 64'(n_load_err), 64'd0);
    chk("t6_rst_ready2", 64'(s_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready", 64'(s_ready), 64'd1);
    chk("t6_nopulse", 64'(n_load_err | n_load_done), 64'd0);
    send_frame(32'h8000_0001, 32'hDEAD_0000, 1'b1);
    expect_commit("t6", 32'h8000_0001, 32'hDEAD_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
